// File: rtl/dma_pkg.sv
// Shared DMA types: descriptors, wrapper status/error, completion records and scheduler state.
package dma_pkg;

  localparam int unsigned DMA_SCHED_DESC_DEPTH = 4;
  localparam int unsigned DMA_SCHED_CMPL_DEPTH = 4;
  localparam int unsigned DMA_SCHED_TAG_W      = 4;
  // Record tag field is sized for the widest supported TAG_W; narrower tags are zero-extended.
  localparam int unsigned DMA_SCHED_TAG_MAX_W  = 8;

  typedef enum logic {
    DMA_ERR_CFG = 1'b0,
    DMA_ERR_OPE = 1'b1
  } dma_err_type_t;

  typedef enum logic {
    DMA_ERR_RD = 1'b0,
    DMA_ERR_WR = 1'b1
  } dma_err_src_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic active;
    logic done;
  } s_dma_status_t;

  typedef struct packed {
    logic          valid;
    dma_err_type_t type_err;
    dma_err_src_t  src;
  } s_dma_error_t;

  typedef struct packed {
    logic [DMA_SCHED_TAG_MAX_W-1:0] tag;
    logic                           err;
    dma_err_type_t                  err_type;
    dma_err_src_t                   err_src;
    logic                           aborted;
  } s_dma_cmpl_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StBusy,
    StReport,
    StFlush
  } dma_sched_st_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy and free-slot counts.
module dma_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_data,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(Depth):0]   o_ocup,
  output logic [$clog2(Depth):0]   o_free
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CntW'(Depth));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_ocup  = r_cnt;
  assign o_free  = CntW'(Depth) - r_cnt;
  // Stale storage is never exposed: an empty FIFO presents all zeros.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Queues DMA descriptors, launches them one at a time into the wrapper and returns tagged
// completion records; an errored transfer can flush the remaining queue as aborted records.
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int unsigned DESC_DEPTH   = DMA_SCHED_DESC_DEPTH,
  parameter int unsigned CMPL_DEPTH   = DMA_SCHED_CMPL_DEPTH,
  parameter int unsigned TAG_W        = DMA_SCHED_TAG_W,
  parameter bit          ABORT_ON_ERR = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_valid_i,
  input  s_dma_desc_t                 push_desc_i,
  output logic                        push_ready_o,
  output logic                        dma_go_o,
  output s_dma_desc_t                 dma_desc_o,
  input  s_dma_status_t               dma_stats_i,
  input  s_dma_error_t                dma_error_i,
  output logic                        cmpl_valid_o,
  output s_dma_cmpl_t                 cmpl_o,
  input  logic                        cmpl_ready_i,
  output logic                        busy_o,
  output logic [$clog2(DESC_DEPTH):0] pend_cnt_o,
  output logic [15:0]                 err_cnt_o
);

  dma_sched_st_t r_state;
  dma_sched_st_t w_state_nxt;

  s_dma_desc_t   w_desc_rdata;
  logic          w_desc_push;
  logic          w_desc_pop;
  logic          w_desc_empty;
  logic          w_desc_full;
  logic [$clog2(DESC_DEPTH):0] w_desc_ocup;
  logic [$clog2(DESC_DEPTH):0] w_desc_free;

  s_dma_cmpl_t   w_cmpl_wdata;
  s_dma_cmpl_t   w_cmpl_rdata;
  logic          w_cmpl_push;
  logic          w_cmpl_pop;
  logic          w_cmpl_empty;
  logic          w_cmpl_full;
  logic [$clog2(CMPL_DEPTH):0] w_cmpl_ocup;
  logic [$clog2(CMPL_DEPTH):0] w_cmpl_free;

  s_dma_desc_t   r_desc;
  logic [TAG_W-1:0] r_tag_cnt;
  logic [TAG_W-1:0] r_tag_cur;
  logic          r_err;
  dma_err_type_t r_err_type;
  dma_err_src_t  r_err_src;
  logic [15:0]   r_err_cnt;

  logic          w_hit;
  logic          w_launch;
  logic          w_flush_step;
  logic          w_unused;

  assign w_hit        = dma_error_i.valid || dma_stats_i.done;
  // Launch only with a completion slot free, so REPORT can never find the FIFO full.
  assign w_launch     = (r_state == StIdle) && !w_desc_empty && (w_cmpl_free != '0);
  assign w_flush_step = (r_state == StFlush) && !w_desc_empty && !w_cmpl_full;

  assign push_ready_o = rst && !w_desc_full && (r_state != StFlush);
  assign w_desc_push  = push_valid_i && push_ready_o;
  assign cmpl_valid_o = !w_cmpl_empty;
  assign cmpl_o       = w_cmpl_rdata;
  assign w_cmpl_pop   = cmpl_valid_o && cmpl_ready_i;
  assign busy_o       = (r_state != StIdle) || !w_desc_empty;
  assign pend_cnt_o   = w_desc_ocup;
  assign err_cnt_o    = r_err_cnt;
  assign dma_desc_o   = r_desc;
  assign w_unused     = ^{dma_stats_i.active, w_desc_free, w_cmpl_ocup};

  dma_sync_fifo #(
    .Width ($bits(s_dma_desc_t)),
    .Depth (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_desc_push),
    .i_data  (push_desc_i),
    .i_pop   (w_desc_pop),
    .o_data  (w_desc_rdata),
    .o_empty (w_desc_empty),
    .o_full  (w_desc_full),
    .o_ocup  (w_desc_ocup),
    .o_free  (w_desc_free)
  );

  dma_sync_fifo #(
    .Width ($bits(s_dma_cmpl_t)),
    .Depth (CMPL_DEPTH)
  ) u_cmpl_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cmpl_push),
    .i_data  (w_cmpl_wdata),
    .i_pop   (w_cmpl_pop),
    .o_data  (w_cmpl_rdata),
    .o_empty (w_cmpl_empty),
    .o_full  (w_cmpl_full),
    .o_ocup  (w_cmpl_ocup),
    .o_free  (w_cmpl_free)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_launch) w_state_nxt = StLaunch;
      StLaunch: w_state_nxt = StBusy;
      StBusy:   if (w_hit) w_state_nxt = StReport;
      StReport: w_state_nxt = (r_err && ABORT_ON_ERR) ? StFlush : StIdle;
      StFlush:  if (w_desc_empty) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    dma_go_o     = (r_state == StLaunch);
    w_desc_pop   = w_launch || w_flush_step;
    w_cmpl_push  = (r_state == StReport) || w_flush_step;
    w_cmpl_wdata = '0;
    if (r_state == StReport) begin
      w_cmpl_wdata.tag      = DMA_SCHED_TAG_MAX_W'(r_tag_cur);
      w_cmpl_wdata.err      = r_err;
      w_cmpl_wdata.err_type = r_err_type;
      w_cmpl_wdata.err_src  = r_err_src;
    end else if (w_flush_step) begin
      w_cmpl_wdata.tag      = DMA_SCHED_TAG_MAX_W'(r_tag_cnt);
      w_cmpl_wdata.aborted  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_desc     <= '0;
      r_tag_cnt  <= '0;
      r_tag_cur  <= '0;
      r_err      <= 1'b0;
      r_err_type <= DMA_ERR_CFG;
      r_err_src  <= DMA_ERR_RD;
      r_err_cnt  <= '0;
    end else begin
      if (w_launch) begin
        r_desc    <= w_desc_rdata;
        r_tag_cur <= r_tag_cnt;
      end
      if (w_launch || w_flush_step) r_tag_cnt <= r_tag_cnt + TAG_W'(1);
      // Error wins over a coincident done.
      if ((r_state == StBusy) && w_hit) begin
        r_err      <= dma_error_i.valid;
        r_err_type <= dma_error_i.valid ? dma_error_i.type_err : DMA_ERR_CFG;
        r_err_src  <= dma_error_i.valid ? dma_error_i.src : DMA_ERR_RD;
        if (dma_error_i.valid) r_err_cnt <= sat_inc16(r_err_cnt);
      end
    end
  end

endmodule
